register_file_scoreboarded: RTL and testbench
=============================================

# register_file_scoreboarded

Parametrised successor to the CPU's fixed 16×32, three-read/one-write register file. It adds configurable width, depth, read-port count and two write ports with a defined priority. It also carries a per-register busy scoreboard that the decode stage uses to detect in-flight producers and to stall. It sits between decode (reads, reservations) and writeback (writes), and an asynchronous reset clears all architectural state.

## Interface
- DATA_WIDTH, 32, bits per register
- NUM_REGS, 16, register count (power of two, ≥ 2); register 0 reads as zero and is never written
- NUM_RD_PORTS, 3, asynchronous read ports
- SEL_W, $clog2(NUM_REGS), derived select width; not overridden

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active low
- rd_sel  in  NUM_RD_PORTS*SEL_W  read selects; port p occupies bits [p*SEL_W +: SEL_W]
- rd_data  out  NUM_RD_PORTS*DATA_WIDTH  read data, packed the same way
- rd_busy  out  NUM_RD_PORTS  busy status of each read port's selected register
- wr_en  in  2  write enables for write ports 0 and 1
- wr_sel  in  2*SEL_W  write selects
- wr_data  in  2*DATA_WIDTH  write data
- rsv_en  in  1  reserve request: mark a register busy (producer issued)
- rsv_sel  in  SEL_W  register to reserve
- flush  in  1  clear every busy bit (pipeline flush)
- dbg_sel  in  SEL_W  debug inspection select
- dbg_data  out  DATA_WIDTH  registered copy of register dbg_sel; raw array value, no bypass
- busy_vec  out  NUM_REGS  full scoreboard; bit 0 is always 0

## Operation
- Storage: NUM_REGS × DATA_WIDTH array plus a NUM_REGS-bit busy vector. Entry 0 and busy[0] stay constant 0.
- Write (posedge): for each port w with wr_en[w]=1 and wr_sel≠0, the array entry takes wr_data.
  - Both ports targeting the same register: port 1 wins.
- Busy update (posedge), evaluated in this priority order:
  1. flush=1: all busy bits cleared; any rsv_en in the same cycle is ignored.
  2. Otherwise, for every valid write (wr_en, sel≠0): busy[sel] is cleared.
  3. Then, rsv_en=1 with rsv_sel≠0: busy[rsv_sel] is set. A reservation overrides a same-cycle write to the same register, so busy stays 1 because a new producer is in flight.
- Read (combinational), per port p, with s = rd_sel[p]:
  - s=0: rd_data=0 and rd_busy=0.
  - A valid write to s this cycle: rd_data is that write's data (port 1 data if both ports match) and rd_busy=0.
  - Otherwise: rd_data=array[s] and rd_busy=busy[s].
  - Reservations and flush are not visible on rd_busy until the next cycle.
- dbg_data: registered array[dbg_sel] each cycle; it shows pre-write contents on the edge a write occurs.

## Timing
- Reset (rst_n=0, asynchronous): all array entries, busy_vec and dbg_data go to 0 immediately, with no clock needed.
  - rd_data/rd_busy then follow combinationally: 0 unless a write bypass is active.
- Deassertion is sampled at the next posedge; writes and reservations are honoured on the first edge with rst_n=1.
- Read latency: 0 cycles (combinational, same-cycle write bypass). Write latency: 1 edge. Debug latency: 1 edge.
- Timing paths:
  - rd_sel → rd_data is combinational through a NUM_RD_PORTS × (mux + 2-way bypass compare).
  - No path exists from rsv_en/flush to any read output.
- Reset asserted mid-cycle with writes pending: the writes are lost and the array stays 0 while rst_n=0.
- Every port may select the same register simultaneously; each port returns an identical result.

## Test plan
- Reset: preload r5=0xDEADBEEF and reserve r5, then pulse rst_n low between edges → busy_vec=0, dbg_data=0 and rd_data for r5 = 0 before the next edge.
- Bypass and priority: same cycle wr_en=2'b11, both sel=3, data0=0x11, data1=0x22, rd_sel port0=3 → rd_data=0x22 that cycle, and r3=0x22 after the edge.
- Zero register: write 0xFFFF to r0 and reserve r0 → rd_data=0, rd_busy=0, busy_vec[0]=0.
- Scoreboard collision: reserve r7, then on the next edge write r7 and reserve r7 together → busy[7] stays 1; rd_busy is 0 only in the write cycle, then 1 after the edge.
- Flush: reserve r2, r4 and r9 over 3 cycles, then assert flush with rsv_en on r6 → busy_vec=0 after the edge, and r6 is not busy.
- Parameter sweep: DATA_WIDTH=16, NUM_REGS=32, NUM_RD_PORTS=4 → random writes checked against a reference model; port-p packing verified at p=3 with sel=31.

Source files
------------

// File: rtl/register_file_scoreboarded_if.sv
// register_file_scoreboarded_if
//   Bundles the decode/writeback-facing signals of the scoreboarded register
//   file. clk and rst_n are not part of the bundle.
//   master : decode/writeback side (drives selects, writes, reservations)
//   slave  : register file side (returns read data, busy status, debug view)
//   Signals:
//     rd_sel   [NUM_RD_PORTS*SEL_W]      read selects, port p at [p*SEL_W +: SEL_W]
//     rd_data  [NUM_RD_PORTS*DATA_WIDTH] read data, packed like rd_sel
//     rd_busy  [NUM_RD_PORTS]            busy status of each selected register
//     wr_en    [2]                       write enables, ports 0 and 1
//     wr_sel   [2*SEL_W]                 write selects
//     wr_data  [2*DATA_WIDTH]            write data
//     rsv_en / rsv_sel                   reserve (mark busy) request
//     flush                              clear whole scoreboard
//     dbg_sel / dbg_data                 registered debug inspection
//     busy_vec [NUM_REGS]                full scoreboard
interface register_file_scoreboarded_if #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned NUM_REGS     = 16,
   parameter int unsigned NUM_RD_PORTS = 3
);
   localparam int unsigned SEL_W = $clog2(NUM_REGS);

   logic [NUM_RD_PORTS*SEL_W-1:0]      rd_sel;
   logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data;
   logic [NUM_RD_PORTS-1:0]            rd_busy;
   logic [1:0]                         wr_en;
   logic [2*SEL_W-1:0]                 wr_sel;
   logic [2*DATA_WIDTH-1:0]            wr_data;
   logic                               rsv_en;
   logic [SEL_W-1:0]                   rsv_sel;
   logic                               flush;
   logic [SEL_W-1:0]                   dbg_sel;
   logic [DATA_WIDTH-1:0]              dbg_data;
   logic [NUM_REGS-1:0]                busy_vec;

   modport master (
      output rd_sel, wr_en, wr_sel, wr_data, rsv_en, rsv_sel, flush, dbg_sel,
      input  rd_data, rd_busy, dbg_data, busy_vec
   );

   modport slave (
      input  rd_sel, wr_en, wr_sel, wr_data, rsv_en, rsv_sel, flush, dbg_sel,
      output rd_data, rd_busy, dbg_data, busy_vec
   );
endinterface

// File: rtl/register_file_scoreboarded.sv
// register_file_scoreboarded
//   Parametrised CPU register file with two prioritised write ports,
//   NUM_RD_PORTS combinational read ports with same-cycle write bypass,
//   a per-register busy scoreboard for decode stalls, and a registered
//   debug read port. Register 0 reads as zero and is never written.
//   Ports:
//     clk   rising-edge clock
//     rst_n asynchronous active-low reset; clears array, scoreboard, dbg_data
//     bus   register_file_scoreboarded_if.slave (see interface header)
//   The parameters must match those of the connected interface instance.
module register_file_scoreboarded #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned NUM_REGS     = 16,
   parameter int unsigned NUM_RD_PORTS = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   register_file_scoreboarded_if.slave bus
);
   localparam int unsigned SEL_W = $clog2(NUM_REGS);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [NUM_REGS-1:0]   busy_q;
   logic [NUM_REGS-1:0]   busy_d;
   logic [DATA_WIDTH-1:0] dbg_q;

   logic [SEL_W-1:0]      w_sel0;
   logic [SEL_W-1:0]      w_sel1;
   logic [DATA_WIDTH-1:0] w_data0;
   logic [DATA_WIDTH-1:0] w_data1;
   logic                  w_vld0;
   logic                  w_vld1;
   logic                  rsv_vld;

   // ------------------------------------------------------------------
   // Write / reserve request decode. A select of 0 is never a valid
   // target, so it neither writes, bypasses nor touches the scoreboard.
   // ------------------------------------------------------------------
   assign w_sel0  = bus.wr_sel[0 +: SEL_W];
   assign w_sel1  = bus.wr_sel[SEL_W +: SEL_W];
   assign w_data0 = bus.wr_data[0 +: DATA_WIDTH];
   assign w_data1 = bus.wr_data[DATA_WIDTH +: DATA_WIDTH];
   assign w_vld0  = bus.wr_en[0] && (w_sel0 != '0);
   assign w_vld1  = bus.wr_en[1] && (w_sel1 != '0);
   assign rsv_vld = bus.rsv_en && (bus.rsv_sel != '0);

   // ------------------------------------------------------------------
   // Scoreboard next state: flush dominates; otherwise writes retire
   // their producer, and a same-cycle reservation re-arms the bit
   // because a newer producer is now in flight.
   // ------------------------------------------------------------------
   always_comb begin
      busy_d = busy_q;
      if (bus.flush) begin
         busy_d = '0;
      end else begin
         if (w_vld0) busy_d[w_sel0] = 1'b0;
         if (w_vld1) busy_d[w_sel1] = 1'b0;
         if (rsv_vld) busy_d[bus.rsv_sel] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // ------------------------------------------------------------------
   // Architectural state. Port 1 is applied after port 0 so it wins a
   // same-register collision. dbg_q samples the array before this
   // edge's writes land.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         busy_q <= '0;
         dbg_q  <= '0;
      end else begin
         if (w_vld0) regs[w_sel0] <= w_data0;
         if (w_vld1) regs[w_sel1] <= w_data1;
         busy_q <= busy_d;
         dbg_q  <= regs[bus.dbg_sel];
      end
   end

   assign bus.busy_vec = busy_q;
   assign bus.dbg_data = dbg_q;

   // ------------------------------------------------------------------
   // Read ports: zero register, then write bypass (port 1 first), then
   // the stored value. A bypassed value is by definition not busy.
   // ------------------------------------------------------------------
   for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
      logic [SEL_W-1:0]      s;
      logic [DATA_WIDTH-1:0] rd_d;
      logic                  rd_b;

      assign s = bus.rd_sel[p*SEL_W +: SEL_W];

      always_comb begin
         rd_d = '0;
         rd_b = 1'b0;
         if (s == '0) begin
            rd_d = '0;
            rd_b = 1'b0;
         end else if (w_vld1 && (w_sel1 == s)) begin
            rd_d = w_data1;
            rd_b = 1'b0;
         end else if (w_vld0 && (w_sel0 == s)) begin
            rd_d = w_data0;
            rd_b = 1'b0;
         end else begin
            rd_d = regs[s];
            rd_b = busy_q[s];
         end
      end

      assign bus.rd_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_d;
      assign bus.rd_busy[p]                          = rd_b;
   end
endmodule

// File: tb/tb_register_file_scoreboarded.sv
// tb_register_file_scoreboarded
//   Two instances: the default 32x16/3-port configuration exercised with
//   directed scenarios, and a 16-bit x 32-register / 4-port configuration
//   driven with random traffic against a behavioural model.
module tb_register_file_scoreboarded;
   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   register_file_scoreboarded_if #(.DATA_WIDTH(32), .NUM_REGS(16), .NUM_RD_PORTS(3)) bus_a ();
   register_file_scoreboarded_if #(.DATA_WIDTH(16), .NUM_REGS(32), .NUM_RD_PORTS(4)) bus_b ();

   register_file_scoreboarded #(.DATA_WIDTH(32), .NUM_REGS(16), .NUM_RD_PORTS(3)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   register_file_scoreboarded #(.DATA_WIDTH(16), .NUM_REGS(32), .NUM_RD_PORTS(4)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural model of instance B
   logic [15:0] mb [32];
   bit          bb [32];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a();
      bus_a.rd_sel  = '0;
      bus_a.wr_en   = '0;
      bus_a.wr_sel  = '0;
      bus_a.wr_data = '0;
      bus_a.rsv_en  = 1'b0;
      bus_a.rsv_sel = '0;
      bus_a.flush   = 1'b0;
      bus_a.dbg_sel = '0;
   endtask

   task automatic idle_b();
      bus_b.rd_sel  = '0;
      bus_b.wr_en   = '0;
      bus_b.wr_sel  = '0;
      bus_b.wr_data = '0;
      bus_b.rsv_en  = 1'b0;
      bus_b.rsv_sel = '0;
      bus_b.flush   = 1'b0;
      bus_b.dbg_sel = '0;
   endtask

   // One clock of instance B: apply inputs, check reads against the model,
   // advance the model by the documented rules, then check registered outputs.
   task automatic cycle_b(input logic [1:0] we, input logic [4:0] ws0, input logic [4:0] ws1,
                          input logic [15:0] wd0, input logic [15:0] wd1,
                          input logic re, input logic [4:0] rs, input logic fl,
                          input logic [19:0] rsel, input logic [4:0] ds);
      logic [4:0]  s;
      logic [15:0] exp_d;
      logic        exp_b;
      logic [15:0] exp_dbg;
      logic [31:0] exp_vec;
      bit          v0;
      bit          v1;
      bus_b.wr_en   = we;
      bus_b.wr_sel  = {ws1, ws0};
      bus_b.wr_data = {wd1, wd0};
      bus_b.rsv_en  = re;
      bus_b.rsv_sel = rs;
      bus_b.flush   = fl;
      bus_b.rd_sel  = rsel;
      bus_b.dbg_sel = ds;
      v0 = we[0] && (ws0 != 0);
      v1 = we[1] && (ws1 != 0);
      #1;
      for (int p = 0; p < 4; p++) begin
         s = rsel[p*5 +: 5];
         if (s == 0) begin
            exp_d = 16'h0;
            exp_b = 1'b0;
         end else if (v1 && ws1 == s) begin
            exp_d = wd1;
            exp_b = 1'b0;
         end else if (v0 && ws0 == s) begin
            exp_d = wd0;
            exp_b = 1'b0;
         end else begin
            exp_d = mb[s];
            exp_b = bb[s];
         end
         check_eq($sformatf("b_rd_data%0d", p), bus_b.rd_data[p*16 +: 16], exp_d);
         check_eq($sformatf("b_rd_busy%0d", p), bus_b.rd_busy[p], exp_b);
      end
      exp_dbg = mb[ds];
      if (v0) mb[ws0] = wd0;
      if (v1) mb[ws1] = wd1;
      if (fl) begin
         for (int i = 0; i < 32; i++) bb[i] = 1'b0;
      end else begin
         if (v0) bb[ws0] = 1'b0;
         if (v1) bb[ws1] = 1'b0;
         if (re && rs != 0) bb[rs] = 1'b1;
      end
      tick();
      for (int i = 0; i < 32; i++) exp_vec[i] = bb[i];
      check_eq("b_dbg_data", bus_b.dbg_data, exp_dbg);
      check_eq("b_busy_vec", bus_b.busy_vec, exp_vec);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [4:0]  r_ws0;
      logic [4:0]  r_ws1;
      logic [4:0]  r_rs;
      logic [19:0] r_rsel;
      n_vec = 0;
      n_err = 0;
      for (int i = 0; i < 32; i++) begin
         mb[i] = '0;
         bb[i] = 1'b0;
      end
      rst_n = 1'b0;
      idle_a();
      idle_b();
      #1;
      check_eq("rst_busy_vec", bus_a.busy_vec, 0);
      check_eq("rst_dbg_data", bus_a.dbg_data, 0);
      check_eq("rst_rd_data0", bus_a.rd_data[31:0], 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // preload r5 and reserve it on the same edge
      bus_a.wr_en   = 2'b01;
      bus_a.wr_sel  = {4'd0, 4'd5};
      bus_a.wr_data = {32'h0, 32'hDEADBEEF};
      bus_a.rsv_en  = 1'b1;
      bus_a.rsv_sel = 4'd5;
      tick();
      idle_a();
      bus_a.dbg_sel = 4'd5;
      bus_a.rd_sel  = {4'd0, 4'd0, 4'd5};
      #1;
      check_eq("pre_busy_vec", bus_a.busy_vec, 16'h0020);
      check_eq("pre_rd_data0", bus_a.rd_data[31:0], 32'hDEADBEEF);
      check_eq("pre_rd_busy0", bus_a.rd_busy[0], 1'b1);
      tick();
      check_eq("pre_dbg_data", bus_a.dbg_data, 32'hDEADBEEF);

      // asynchronous reset between edges
      rst_n = 1'b0;
      #1;
      check_eq("arst_busy_vec", bus_a.busy_vec, 0);
      check_eq("arst_dbg_data", bus_a.dbg_data, 0);
      check_eq("arst_rd_data0", bus_a.rd_data[31:0], 0);
      check_eq("arst_rd_busy0", bus_a.rd_busy[0], 1'b0);
      bus_a.wr_en   = 2'b01;
      bus_a.wr_sel  = {4'd0, 4'd5};
      bus_a.wr_data = {32'h0, 32'h00001234};
      #1;
      check_eq("arst_bypass", bus_a.rd_data[31:0], 32'h00001234);
      tick();
      idle_a();
      bus_a.dbg_sel = 4'd5;
      bus_a.rd_sel  = {4'd0, 4'd0, 4'd5};
      rst_n = 1'b1;
      #1;
      check_eq("arst_wr_lost", bus_a.rd_data[31:0], 0);
      tick();
      check_eq("arst_dbg_lost", bus_a.dbg_data, 0);

      // dual write to r3: port 1 wins, bypass shows it on every port
      idle_a();
      bus_a.wr_en   = 2'b11;
      bus_a.wr_sel  = {4'd3, 4'd3};
      bus_a.wr_data = {32'h22, 32'h11};
      bus_a.rd_sel  = {4'd3, 4'd3, 4'd3};
      #1;
      for (int p = 0; p < 3; p++) begin
         check_eq($sformatf("byp_rd_data%0d", p), bus_a.rd_data[p*32 +: 32], 32'h22);
         check_eq($sformatf("byp_rd_busy%0d", p), bus_a.rd_busy[p], 1'b0);
      end
      tick();
      idle_a();
      bus_a.rd_sel = {4'd0, 4'd0, 4'd3};
      #1;
      check_eq("prio_r3", bus_a.rd_data[31:0], 32'h22);

      // debug shows pre-write contents on the write edge
      idle_a();
      bus_a.dbg_sel = 4'd3;
      bus_a.wr_en   = 2'b01;
      bus_a.wr_sel  = {4'd0, 4'd3};
      bus_a.wr_data = {32'h0, 32'h33};
      tick();
      check_eq("dbg_prewrite", bus_a.dbg_data, 32'h22);
      idle_a();
      bus_a.dbg_sel = 4'd3;
      tick();
      check_eq("dbg_postwrite", bus_a.dbg_data, 32'h33);

      // register 0 ignores writes and reservations
      idle_a();
      bus_a.wr_en   = 2'b01;
      bus_a.wr_sel  = {4'd0, 4'd0};
      bus_a.wr_data = {32'h0, 32'hFFFF};
      bus_a.rsv_en  = 1'b1;
      bus_a.rsv_sel = 4'd0;
      #1;
      check_eq("r0_rd_data", bus_a.rd_data[31:0], 0);
      check_eq("r0_rd_busy", bus_a.rd_busy[0], 1'b0);
      tick();
      idle_a();
      #1;
      check_eq("r0_busy_vec", bus_a.busy_vec, 0);
      check_eq("r0_rd_after", bus_a.rd_data[31:0], 0);

      // scoreboard collision on r7
      bus_a.rsv_en  = 1'b1;
      bus_a.rsv_sel = 4'd7;
      bus_a.rd_sel  = {4'd0, 4'd7, 4'd0};
      #1;
      check_eq("rsv_not_visible", bus_a.rd_busy[1], 1'b0);
      tick();
      idle_a();
      bus_a.rd_sel = {4'd0, 4'd7, 4'd0};
      #1;
      check_eq("r7_busy_vec", bus_a.busy_vec, 16'h0080);
      check_eq("r7_rd_busy", bus_a.rd_busy[1], 1'b1);
      bus_a.wr_en   = 2'b01;
      bus_a.wr_sel  = {4'd0, 4'd7};
      bus_a.wr_data = {32'h0, 32'h77};
      bus_a.rsv_en  = 1'b1;
      bus_a.rsv_sel = 4'd7;
      #1;
      check_eq("coll_rd_busy", bus_a.rd_busy[1], 1'b0);
      check_eq("coll_rd_data", bus_a.rd_data[63:32], 32'h77);
      tick();
      idle_a();
      bus_a.rd_sel = {4'd0, 4'd7, 4'd0};
      #1;
      check_eq("coll_busy_after", bus_a.rd_busy[1], 1'b1);
      check_eq("coll_busy_vec", bus_a.busy_vec, 16'h0080);
      // a plain write retires the producer
      bus_a.wr_en   = 2'b10;
      bus_a.wr_sel  = {4'd7, 4'd0};
      bus_a.wr_data = {32'h78, 32'h0};
      tick();
      idle_a();
      bus_a.rd_sel = {4'd0, 4'd7, 4'd0};
      #1;
      check_eq("retire_busy_vec", bus_a.busy_vec, 0);
      check_eq("retire_rd_busy", bus_a.rd_busy[1], 1'b0);
      check_eq("retire_rd_data", bus_a.rd_data[63:32], 32'h78);

      // flush beats a same-cycle reservation
      idle_a();
      bus_a.rsv_en  = 1'b1;
      bus_a.rsv_sel = 4'd2;
      tick();
      bus_a.rsv_sel = 4'd4;
      tick();
      bus_a.rsv_sel = 4'd9;
      tick();
      idle_a();
      #1;
      check_eq("flush_pre_vec", bus_a.busy_vec, 16'h0214);
      bus_a.flush   = 1'b1;
      bus_a.rsv_en  = 1'b1;
      bus_a.rsv_sel = 4'd6;
      tick();
      idle_a();
      bus_a.rd_sel = {4'd6, 4'd0, 4'd0};
      #1;
      check_eq("flush_busy_vec", bus_a.busy_vec, 0);
      check_eq("flush_r6_busy", bus_a.rd_busy[2], 1'b0);

      // wide configuration: port 3 packing with r31
      cycle_b(2'b01, 5'd31, 5'd0, 16'hBEEF, 16'h0, 1'b0, 5'd0, 1'b0,
              {5'd31, 5'd0, 5'd0, 5'd0}, 5'd31);
      cycle_b(2'b00, 5'd0, 5'd0, 16'h0, 16'h0, 1'b1, 5'd31, 1'b0,
              {5'd31, 5'd0, 5'd0, 5'd31}, 5'd31);
      cycle_b(2'b00, 5'd0, 5'd0, 16'h0, 16'h0, 1'b0, 5'd0, 1'b0,
              {5'd31, 5'd1, 5'd2, 5'd0}, 5'd31);

      // random traffic with deliberate collisions
      for (int n = 0; n < 400; n++) begin
         r_ws0 = 5'($urandom_range(0, 31));
         r_ws1 = ($urandom_range(0, 3) == 0) ? r_ws0 : 5'($urandom_range(0, 31));
         r_rs  = ($urandom_range(0, 3) == 0) ? r_ws0 : 5'($urandom_range(0, 31));
         for (int p = 0; p < 4; p++) begin
            case ($urandom_range(0, 3))
               0: r_rsel[p*5 +: 5] = r_ws0;
               1: r_rsel[p*5 +: 5] = r_ws1;
               default: r_rsel[p*5 +: 5] = 5'($urandom_range(0, 31));
            endcase
         end
         cycle_b(2'($urandom_range(0, 3)), r_ws0, r_ws1,
                 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 1)), r_rs,
                 ($urandom_range(0, 15) == 0),
                 r_rsel, 5'($urandom_range(0, 31)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
